// File: rtl/serial_packet_sender_if.sv
// Parallel-side bundle of the serial packet sender.
// The master drives tick, start, len and data. The slave returns the line and status.
interface serial_packet_sender_if #(
   parameter int DATA_W = 15
);
   logic              tick;
   logic              start;
   logic [3:0]        len;
   logic [DATA_W-1:0] data;
   logic              serOut;
   logic              busy;
   logic              done;
   logic [3:0]        bits_left;

   modport master (
      output tick, start, len, data,
      input  serOut, busy, done, bits_left
   );

   modport slave (
      input  tick, start, len, data,
      output serOut, busy, done, bits_left
   );
endinterface

// File: rtl/serial_packet_sender.sv
// Frames a parallel payload as header, 4-bit length, then payload bits, all MSB first.
// The line advances one bit per tick.
//
// state | meaning
// IDLE  | line low, waiting for start
// HDR   | shifting HEADER[3..0]
// LEN   | shifting len_r[3..0]
// DATA  | shifting data_r[len_r-1..0]; bits_left counts down
// DONE  | single-cycle done pulse, then back to IDLE
module serial_packet_sender #(
   parameter logic [3:0] HEADER = 4'b1101,
   parameter int         DATA_W = 15
) (
   input logic                  clk,
   input logic                  rst,
   serial_packet_sender_if.slave link
);

   if (DATA_W != 15) begin : g_width_check
      $error("DATA_W must be 15, the largest count the 4-bit length field can express");
   end

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      LEN  = 3'd2,
      DATA = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic [3:0]        idx, idx_nxt;
   logic [3:0]        len_r, len_nxt;
   logic [DATA_W-1:0] data_r, data_nxt;
   logic              ser_r, ser_nxt;
   logic [3:0]        bl_r, bl_nxt;
   logic [3:0]        idx_dec;
   logic [3:0]        len_dec;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= 4'd0;
         len_r  <= 4'd0;
         data_r <= '0;
         ser_r  <= 1'b0;
         bl_r   <= 4'd0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         len_r  <= len_nxt;
         data_r <= data_nxt;
         ser_r  <= ser_nxt;
         bl_r   <= bl_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      len_nxt   = len_r;
      data_nxt  = data_r;
      ser_nxt   = ser_r;
      bl_nxt    = bl_r;
      idx_dec   = idx - 4'd1;
      len_dec   = len_r - 4'd1;

      case (state)
         IDLE: begin
            ser_nxt = 1'b0;
            bl_nxt  = 4'd0;
            // A tick arriving together with start is deliberately not counted as a bit advance.
            if (link.start) begin
               len_nxt   = link.len;
               data_nxt  = link.data;
               idx_nxt   = 4'd3;
               ser_nxt   = HEADER[3];
               bl_nxt    = link.len;
               state_nxt = HDR;
            end
         end
         HDR: begin
            if (link.tick) begin
               if (idx != 4'd0) begin
                  idx_nxt = idx_dec;
                  ser_nxt = HEADER[idx_dec[1:0]];
               end else begin
                  idx_nxt   = 4'd3;
                  ser_nxt   = len_r[3];
                  state_nxt = LEN;
               end
            end
         end
         LEN: begin
            if (link.tick) begin
               if (idx != 4'd0) begin
                  idx_nxt = idx_dec;
                  ser_nxt = len_r[idx_dec[1:0]];
               end else if (len_r != 4'd0) begin
                  idx_nxt   = len_dec;
                  ser_nxt   = data_r[len_dec];
                  state_nxt = DATA;
               end else begin
                  idx_nxt   = 4'd0;
                  ser_nxt   = 1'b0;
                  bl_nxt    = 4'd0;
                  state_nxt = DONE;
               end
            end
         end
         DATA: begin
            if (link.tick) begin
               bl_nxt = bl_r - 4'd1;
               if (idx != 4'd0) begin
                  idx_nxt = idx_dec;
                  ser_nxt = data_r[idx_dec];
               end else begin
                  ser_nxt   = 1'b0;
                  bl_nxt    = 4'd0;
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            ser_nxt   = 1'b0;
            bl_nxt    = 4'd0;
            state_nxt = IDLE;
         end
         default: begin
            ser_nxt   = 1'b0;
            bl_nxt    = 4'd0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign link.serOut    = ser_r;
   assign link.busy      = (state == HDR) || (state == LEN) || (state == DATA);
   assign link.done      = (state == DONE);
   assign link.bits_left = bl_r;

endmodule

// File: tb/tb_serial_packet_sender.sv
// Scoreboard bench for serial_packet_sender: stimulus queues the expected line bits,
// and a negedge monitor checks each bit as it is consumed by a tick.
module tb_serial_packet_sender;

   logic clk = 1'b0;
   logic rst = 1'b1;

   serial_packet_sender_if #(.DATA_W(15)) link ();

   serial_packet_sender dut (
      .clk  (clk),
      .rst  (rst),
      .link (link)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       b;
      int         hold;
      logic [3:0] bl;
   } exp_t;

   exp_t bit_q[$];
   int   done_q[$];
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   int   run = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // s is the expected line bit string; hold is the expected number of clocks per bit.
   task automatic push_packet(input string s, input int ln, input int hold);
      exp_t e;
      for (int j = 0; j < s.len(); j++) begin
         e.b    = (s[j] == "1");
         e.hold = hold;
         e.bl   = (j < 8) ? 4'(ln) : 4'(ln - (j - 8));
         bit_q.push_back(e);
      end
      done_q.push_back(1);
   endtask

   task automatic send(input logic [3:0] ln, input logic [14:0] d, input logic tk);
      link.start = 1'b1;
      link.len   = ln;
      link.data  = d;
      link.tick  = tk;
      cyc();
      link.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      int d0;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         cyc();
         n++;
      end
      check("done_timeout", (done_cnt > d0) ? 1 : 0, 1);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            run = 0;
         end else begin
            if (link.busy) begin
               run++;
               if (link.tick) begin
                  if (bit_q.size() == 0) begin
                     check("unexpected_bit", 1, 0);
                  end else begin
                     e = bit_q.pop_front();
                     check("serOut", int'(link.serOut), int'(e.b));
                     check("bit_hold", run, e.hold);
                     check("bits_left", int'(link.bits_left), int'(e.bl));
                  end
                  run = 0;
               end
            end else begin
               run = 0;
            end
            if (link.done) begin
               done_cnt++;
               check("unexpected_done", (done_q.size() != 0) ? 1 : 0, 1);
               if (done_q.size() != 0) void'(done_q.pop_front());
               check("done_busy", int'(link.busy), 0);
               check("done_serOut", int'(link.serOut), 0);
               check("done_bits_left", int'(link.bits_left), 0);
               check("bits_missing_at_done", bit_q.size(), 0);
            end
         end
      end
   end

   initial begin
      int n;
      int d0;
      link.start = 1'b0;
      link.tick  = 1'b0;
      link.len   = 4'd0;
      link.data  = 15'd0;

      repeat (2) cyc();
      rst = 1'b0;
      check("rst_serOut", int'(link.serOut), 0);
      check("rst_busy", int'(link.busy), 0);
      check("rst_done", int'(link.done), 0);
      check("rst_bits_left", int'(link.bits_left), 0);

      // len=5, constant tick, start and tick together in IDLE
      push_packet("1101010110110", 5, 1);
      send(4'd5, 15'b000000000010110, 1'b1);
      check("busy_after_accept", int'(link.busy), 1);
      check("bits_left_after_accept", int'(link.bits_left), 5);
      wait_done(40, n);
      check("latency_len5", n, 14);
      link.tick = 1'b0;
      repeat (3) cyc();

      // len=0: no payload bits
      push_packet("11010000", 0, 1);
      send(4'd0, 15'h7FFF, 1'b1);
      wait_done(40, n);
      check("latency_len0", n, 9);
      link.tick = 1'b0;
      repeat (3) cyc();

      // sparse tick, one every 4 clocks
      push_packet("11010011101", 3, 4);
      send(4'd3, 15'b000000000000101, 1'b0);
      for (int i = 0; i < 11; i++) begin
         repeat (3) cyc();
         link.tick = 1'b1;
         cyc();
         link.tick = 1'b0;
      end
      wait_done(10, n);
      repeat (3) cyc();

      // start and new len/data applied during LEN are ignored
      push_packet("1101001010", 2, 1);
      send(4'd2, 15'b000000000000010, 1'b1);
      repeat (5) cyc();
      link.start = 1'b1;
      link.len   = 4'd7;
      link.data  = 15'h007F;
      repeat (2) cyc();
      link.start = 1'b0;
      wait_done(40, n);
      repeat (3) cyc();
      push_packet("110101111010101", 7, 1);
      send(4'd7, 15'h0055, 1'b1);
      wait_done(40, n);
      check("latency_len7", n, 16);
      link.tick = 1'b0;
      repeat (3) cyc();

      // full-length payload
      push_packet("11011111101101000111100", 15, 1);
      send(4'd15, 15'h5A3C, 1'b1);
      wait_done(60, n);
      check("latency_len15", n, 24);
      repeat (3) cyc();

      // reset mid-header abandons the packet without a done pulse
      push_packet("1101010110110", 5, 1);
      send(4'd5, 15'b000000000010110, 1'b1);
      cyc();
      rst = 1'b1;
      bit_q.delete();
      done_q.delete();
      d0 = done_cnt;
      cyc();
      check("midrst_serOut", int'(link.serOut), 0);
      check("midrst_busy", int'(link.busy), 0);
      cyc();
      rst = 1'b0;
      check("postrst_serOut", int'(link.serOut), 0);
      check("postrst_busy", int'(link.busy), 0);
      check("postrst_done", int'(link.done), 0);
      check("postrst_bits_left", int'(link.bits_left), 0);
      repeat (20) cyc();
      check("no_done_after_rst", done_cnt, d0);
      push_packet("110100011", 1, 1);
      send(4'd1, 15'h0001, 1'b1);
      wait_done(40, n);
      check("latency_after_rst", n, 10);
      link.tick = 1'b0;
      repeat (3) cyc();

      check("bit_q_empty", bit_q.size(), 0);
      check("done_q_empty", done_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
